audio_period_monitor: RTL and testbench
=======================================

AUDIO_PERIOD_MONITOR -- requirements
Module: audio_period_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of audio channels monitored.
REQ-002 SHALL have parameter DATA_W, default 16: signed sample width.
REQ-003 SHALL have parameter CNT_W, default 8: width of the per-period sample counter.
REQ-004 SHALL have parameter ERR_W, default 12: width of each error counter.
REQ-005 SHALL have port clk  in  1: system clock; the block uses one clock, and all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port smpl  in  NUM_CH*DATA_W: signed samples, with channel c at bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port vld  in  1: one-cycle strobe; smpl is valid for all channels in that cycle.
REQ-009 SHALL have port start  in  1: pulse that begins a measurement run.
REQ-010 SHALL have port abort  in  1: pulse that ends a run early.
REQ-011 SHALL have port settle_xing  in  4: number of crossings per channel that are discarded before checking starts.
REQ-012 SHALL have port num_periods  in  ERR_W: number of periods checked per channel.
REQ-013 SHALL have port min_cnt, max_cnt  in  CNT_W: inclusive limits on samples per period.
REQ-014 SHALL have port min_ampl, max_ampl  in  DATA_W: inclusive signed limits on the peak value per period.
REQ-015 SHALL have port busy, done  out  1: run status.
REQ-016 SHALL have port freq_err, ampl_err  out  NUM_CH*ERR_W: per-channel error counts.
REQ-017 SHALL have port stall  out  NUM_CH: per-channel flag for "no crossing found before the counter saturated".
REQ-018 SHALL have port last_cnt  out  NUM_CH*CNT_W and port last_peak  out  NUM_CH*DATA_W: values from the most recently completed period.

Function
REQ-019 The global FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-020 start in IDLE or DONE SHALL do all of the following on the same edge: enter RUN; clear all error counters, stall, settle counts, period counts, sample counts and peaks.
REQ-021 start in RUN SHALL be ignored.
REQ-022 abort in RUN SHALL return to IDLE with all counters and outputs holding their values.
REQ-023 abort SHALL take priority over a simultaneous start or finish.
REQ-024 Per channel, a crossing SHALL be a vld cycle where the previous valid sample is negative (MSB=1) and the current sample is non-negative.
REQ-025 The previous-sample sign SHALL update on every vld, in all states.
REQ-026 Per channel in RUN, every vld SHALL increment the sample count, saturating at 2^CNT_W-1.
REQ-027 Per channel in RUN, every vld SHALL set peak = max(peak, sample), compared as signed.
REQ-028 Per channel, the first settle_xing crossings SHALL only increment the settle count, restart the sample count at 1 and set peak to the current sample; no checks are performed.
REQ-029 After settling, each crossing SHALL close one period.
REQ-030 When a period closes, freq_err SHALL increment if count<min_cnt or count>max_cnt.
REQ-031 When a period closes, ampl_err SHALL increment if peak<min_ampl or peak>max_ampl.
REQ-032 When a period closes, last_cnt and last_peak SHALL load the closed period's count and peak, the period count SHALL increment, and the sample count and peak SHALL restart with the crossing sample (count=1).
REQ-033 The first checked period SHALL be the one that starts at the last settling crossing.
REQ-034 Error counters SHALL saturate at 2^ERR_W-1.
REQ-035 If the sample count reaches 2^CNT_W-1 with no crossing, stall[c] SHALL set and channel c SHALL be finished.
REQ-036 Channel c SHALL be finished when its period count equals num_periods or stall[c]=1.
REQ-037 A finished channel SHALL stop checking.
REQ-038 RUN->DONE SHALL occur on the edge after all channels are finished.
REQ-039 num_periods=0 SHALL make the run finish immediately after settling.
REQ-040 Channels SHALL operate independently.
REQ-041 A crossing on the same cycle as the count saturating SHALL close the period normally and SHALL NOT set stall.
REQ-042 Latency SHALL be one clock from the vld edge to the updated counters, last_cnt and last_peak.
REQ-043 vld outside RUN SHALL affect only the previous-sample sign register.

Reset
REQ-044 On rst_n low, asynchronously: FSM=IDLE; busy=0, done=0; freq_err=ampl_err=0; stall=0; last_cnt=0, last_peak=0; every internal counter=0; every previous-sample sign=0 (non-negative).
REQ-045 Reset mid-run SHALL discard the run; a new start is required after release.

Verification
REQ-046 NUM_CH=2; 16-sample/period sine, amplitude 4000, both channels; settle_xing=2, num_periods=8, cnt 12..20, ampl 2500..14000 -> done=1, errors=0, last_cnt=16, last_peak≈4000.
REQ-047 Same as REQ-046 but ch1 amplitude 2000 -> ch1 ampl_err=8, ch1 freq_err=0, ch0 counts 0.
REQ-048 ch0 period 24 samples, ch1 period 16 -> ch0 freq_err=8, last_cnt=24; ch1 freq_err=0.
REQ-049 ch1 held at constant -100 -> stall[1]=1 after 255 samples past settling; done is reached once ch0 finishes its 8 periods.
REQ-050 abort after 3 periods -> IDLE, busy=0, counters hold; rst_n pulse mid-run -> all outputs 0 asynchronously.
REQ-051 start pulsed during RUN -> no counter clear; start in DONE -> counters cleared and RUN re-entered.

Source files
------------

// File: rtl/audio_period_monitor.sv
// Per-channel audio period/amplitude monitor: counts samples and tracks peak between
// rising zero crossings, and flags periods whose length or peak falls outside the limits.
module audio_period_monitor #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8,
   parameter int ERR_W  = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH*DATA_W-1:0]   smpl,
   input  logic                       vld,
   input  logic                       start,
   input  logic                       abort,
   input  logic [3:0]                 settle_xing,
   input  logic [ERR_W-1:0]           num_periods,
   input  logic [CNT_W-1:0]           min_cnt,
   input  logic [CNT_W-1:0]           max_cnt,
   input  logic [DATA_W-1:0]          min_ampl,
   input  logic [DATA_W-1:0]          max_ampl,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_CH*ERR_W-1:0]    freq_err,
   output logic [NUM_CH*ERR_W-1:0]    ampl_err,
   output logic [NUM_CH-1:0]          stall,
   output logic [NUM_CH*CNT_W-1:0]    last_cnt,
   output logic [NUM_CH*DATA_W-1:0]   last_peak
);

   // state   | meaning
   // ST_IDLE | waiting for start; counters hold
   // ST_RUN  | channels settle, then check periods
   // ST_DONE | every channel finished; results hold
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t state_q, state_d;
   logic   clear, upd;

   logic [NUM_CH-1:0]        sign_q, sign_d;
   logic [NUM_CH-1:0]        stall_q, stall_d;
   logic [NUM_CH-1:0]        fin, xing;
   logic [3:0]               settle_q [NUM_CH];
   logic [3:0]               settle_d [NUM_CH];
   logic [ERR_W-1:0]         per_q    [NUM_CH];
   logic [ERR_W-1:0]         per_d    [NUM_CH];
   logic [ERR_W-1:0]         ferr_q   [NUM_CH];
   logic [ERR_W-1:0]         ferr_d   [NUM_CH];
   logic [ERR_W-1:0]         aerr_q   [NUM_CH];
   logic [ERR_W-1:0]         aerr_d   [NUM_CH];
   logic [CNT_W-1:0]         cnt_q    [NUM_CH];
   logic [CNT_W-1:0]         cnt_d    [NUM_CH];
   logic [CNT_W-1:0]         lcnt_q   [NUM_CH];
   logic [CNT_W-1:0]         lcnt_d   [NUM_CH];
   logic signed [DATA_W-1:0] peak_q   [NUM_CH];
   logic signed [DATA_W-1:0] peak_d   [NUM_CH];
   logic signed [DATA_W-1:0] lpeak_q  [NUM_CH];
   logic signed [DATA_W-1:0] lpeak_d  [NUM_CH];
   logic signed [DATA_W-1:0] smp      [NUM_CH];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         fin[c] = stall_q[c] | ((settle_q[c] >= settle_xing) && (per_q[c] >= num_periods));
      end
   end

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               clear   = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort)     state_d = ST_IDLE;
            else if (&fin) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // An aborting edge freezes every channel, including a coincident sample.
   assign upd  = (state_q == ST_RUN) && !abort;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         smp[c]      = $signed(smpl[c*DATA_W +: DATA_W]);
         xing[c]     = sign_q[c] & ~smp[c][DATA_W-1];
         sign_d[c]   = vld ? smp[c][DATA_W-1] : sign_q[c];
         stall_d[c]  = stall_q[c];
         settle_d[c] = settle_q[c];
         per_d[c]    = per_q[c];
         ferr_d[c]   = ferr_q[c];
         aerr_d[c]   = aerr_q[c];
         cnt_d[c]    = cnt_q[c];
         lcnt_d[c]   = lcnt_q[c];
         peak_d[c]   = peak_q[c];
         lpeak_d[c]  = lpeak_q[c];
         if (clear) begin
            stall_d[c]  = 1'b0;
            settle_d[c] = '0;
            per_d[c]    = '0;
            ferr_d[c]   = '0;
            aerr_d[c]   = '0;
            cnt_d[c]    = '0;
            lcnt_d[c]   = '0;
            peak_d[c]   = '0;
            lpeak_d[c]  = '0;
         end else if (upd && vld && !fin[c]) begin
            if (xing[c]) begin
               if (settle_q[c] < settle_xing) begin
                  settle_d[c] = settle_q[c] + 4'd1;
               end else begin
                  if ((cnt_q[c] < min_cnt || cnt_q[c] > max_cnt) && ferr_q[c] != ERR_MAX)
                     ferr_d[c] = ferr_q[c] + 1'b1;
                  if ((peak_q[c] < $signed(min_ampl) || peak_q[c] > $signed(max_ampl)) &&
                      aerr_q[c] != ERR_MAX)
                     aerr_d[c] = aerr_q[c] + 1'b1;
                  lcnt_d[c]  = cnt_q[c];
                  lpeak_d[c] = peak_q[c];
                  per_d[c]   = per_q[c] + 1'b1;
               end
               // The crossing sample opens the next period.
               cnt_d[c]  = CNT_ONE;
               peak_d[c] = smp[c];
            end else begin
               cnt_d[c] = (cnt_q[c] == CNT_MAX) ? CNT_MAX : cnt_q[c] + 1'b1;
               if (smp[c] > peak_q[c]) peak_d[c] = smp[c];
               if (cnt_d[c] == CNT_MAX) stall_d[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sign_q  <= '0;
         stall_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            settle_q[c] <= '0;
            per_q[c]    <= '0;
            ferr_q[c]   <= '0;
            aerr_q[c]   <= '0;
            cnt_q[c]    <= '0;
            lcnt_q[c]   <= '0;
            peak_q[c]   <= '0;
            lpeak_q[c]  <= '0;
         end
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         stall_q <= stall_d;
         for (int c = 0; c < NUM_CH; c++) begin
            settle_q[c] <= settle_d[c];
            per_q[c]    <= per_d[c];
            ferr_q[c]   <= ferr_d[c];
            aerr_q[c]   <= aerr_d[c];
            cnt_q[c]    <= cnt_d[c];
            lcnt_q[c]   <= lcnt_d[c];
            peak_q[c]   <= peak_d[c];
            lpeak_q[c]  <= lpeak_d[c];
         end
      end
   end

   always_comb begin
      freq_err  = '0;
      ampl_err  = '0;
      last_cnt  = '0;
      last_peak = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         freq_err[c*ERR_W +: ERR_W]   = ferr_q[c];
         ampl_err[c*ERR_W +: ERR_W]   = aerr_q[c];
         last_cnt[c*CNT_W +: CNT_W]   = lcnt_q[c];
         last_peak[c*DATA_W +: DATA_W] = lpeak_q[c];
      end
   end

   assign stall = stall_q;

endmodule

// File: tb/tb_audio_period_monitor.sv
// Directed scenarios for audio_period_monitor; expectations are queued by the
// stimulus and compared against the DUT outputs by an independent monitor.
module tb_audio_period_monitor;

   localparam int NUM_CH = 2;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;
   localparam int ERR_W  = 12;
   localparam real PI    = 3.14159265358979;

   localparam int F_FERR  = 0;
   localparam int F_AERR  = 1;
   localparam int F_LCNT  = 2;
   localparam int F_LPEAK = 3;
   localparam int F_STALL = 4;
   localparam int F_BUSY  = 5;
   localparam int F_DONE  = 6;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_CH*DATA_W-1:0] smpl = '0;
   logic                     vld = 1'b0;
   logic                     start = 1'b0;
   logic                     abort = 1'b0;
   logic [3:0]               settle_xing = '0;
   logic [ERR_W-1:0]         num_periods = '0;
   logic [CNT_W-1:0]         min_cnt = '0;
   logic [CNT_W-1:0]         max_cnt = '0;
   logic [DATA_W-1:0]        min_ampl = '0;
   logic [DATA_W-1:0]        max_ampl = '0;
   logic                     busy, done;
   logic [NUM_CH*ERR_W-1:0]  freq_err, ampl_err;
   logic [NUM_CH-1:0]        stall;
   logic [NUM_CH*CNT_W-1:0]  last_cnt;
   logic [NUM_CH*DATA_W-1:0] last_peak;

   audio_period_monitor #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .smpl(smpl), .vld(vld), .start(start), .abort(abort),
      .settle_xing(settle_xing), .num_periods(num_periods),
      .min_cnt(min_cnt), .max_cnt(max_cnt), .min_ampl(min_ampl), .max_ampl(max_ampl),
      .busy(busy), .done(done), .freq_err(freq_err), .ampl_err(ampl_err),
      .stall(stall), .last_cnt(last_cnt), .last_peak(last_peak)
   );

   always #5 clk = ~clk;

   typedef struct {
      string  nm;
      int     f;
      int     c;
      longint v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   amp[2];
   int   per[2];
   int   cfrom[2];

   function automatic longint dut_val(int f, int c);
      logic signed [DATA_W-1:0] pk;
      case (f)
         F_FERR:  return longint'(freq_err[c*ERR_W +: ERR_W]);
         F_AERR:  return longint'(ampl_err[c*ERR_W +: ERR_W]);
         F_LCNT:  return longint'(last_cnt[c*CNT_W +: CNT_W]);
         F_LPEAK: begin
            pk = last_peak[c*DATA_W +: DATA_W];
            return longint'(pk);
         end
         F_STALL: return longint'(stall[c]);
         F_BUSY:  return longint'(busy);
         default: return longint'(done);
      endcase
   endfunction

   // Monitor: whenever expectations are pending, compare them on the falling edge.
   initial begin
      exp_t   e;
      longint act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = dut_val(e.f, e.c);
            checks++;
            if (act != e.v) begin
               errors++;
               $display("FAIL %s ch%0d: got %0d expected %0d", e.nm, e.c, act, e.v);
            end
         end
      end
   end

   task automatic expect_val(string nm, int f, int c, longint v);
      exp_t e;
      e.nm = nm; e.f = f; e.c = c; e.v = v;
      q.push_back(e);
   endtask

   task automatic exp_all(string t, int fe0, int fe1, int ae0, int ae1, int lc0, int lc1,
                          int lp0, int lp1, int st0, int st1, int b, int d);
      expect_val({t, ".freq_err"},  F_FERR,  0, fe0);
      expect_val({t, ".freq_err"},  F_FERR,  1, fe1);
      expect_val({t, ".ampl_err"},  F_AERR,  0, ae0);
      expect_val({t, ".ampl_err"},  F_AERR,  1, ae1);
      expect_val({t, ".last_cnt"},  F_LCNT,  0, lc0);
      expect_val({t, ".last_cnt"},  F_LCNT,  1, lc1);
      expect_val({t, ".last_peak"}, F_LPEAK, 0, lp0);
      expect_val({t, ".last_peak"}, F_LPEAK, 1, lp1);
      expect_val({t, ".stall"},     F_STALL, 0, st0);
      expect_val({t, ".stall"},     F_STALL, 1, st1);
      expect_val({t, ".busy"},      F_BUSY,  0, b);
      expect_val({t, ".done"},      F_DONE,  0, d);
   endtask

   task automatic chk_int(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sval(int c, int idx);
      real ph;
      if (idx >= cfrom[c]) return -100;
      ph = 2.0 * PI * real'(idx % per[c]) / real'(per[c]);
      return int'(real'(amp[c]) * $sin(ph));
   endfunction

   task automatic set_sample(int idx);
      smpl = {16'(sval(1, idx)), 16'(sval(0, idx))};
      vld  = 1'b1;
   endtask

   task automatic setup(int sx, int np, int mnc, int mxc, int mna, int mxa,
                        int a0, int a1, int p0, int p1);
      settle_xing = 4'(sx);
      num_periods = 12'(np);
      min_cnt     = 8'(mnc);
      max_cnt     = 8'(mxc);
      min_ampl    = 16'(mna);
      max_ampl    = 16'(mxa);
      amp[0] = a0; amp[1] = a1;
      per[0] = p0; per[1] = p1;
      cfrom[0] = 1 << 30; cfrom[1] = 1 << 30;
      vld = 1'b0; start = 1'b0; abort = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed(int first, int count);
      for (int i = 0; i < count; i++) begin
         set_sample(first + i);
         step();
      end
      vld = 1'b0;
   endtask

   // Drives samples until done is seen; n = samples driven, or -1 on timeout.
   task automatic run(int first, int max_n, int mid_at, output int n);
      bit seen;
      seen = 1'b0;
      n = -1;
      for (int i = 0; i < max_n && !seen; i++) begin
         set_sample(first + i);
         step();
         if (i == mid_at) begin
            expect_val("mid.busy",  F_BUSY,  0, 1);
            expect_val("mid.stall", F_STALL, 0, 0);
            expect_val("mid.stall", F_STALL, 1, 0);
         end
         if (done) begin
            seen = 1'b1;
            n = i + 1;
         end
      end
      vld = 1'b0;
   endtask

   initial begin
      int n;
      step();
      exp_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 4000, 16, 16);
      run(0, 1000, -1, n);
      chk_int("base.latency", n, 162);
      exp_all("base", 0, 0, 0, 0, 16, 16, 4000, 4000, 0, 0, 0, 1);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 2000, 16, 16);
      run(0, 1000, -1, n);
      chk_int("lowamp.latency", n, 162);
      exp_all("lowamp", 0, 0, 0, 8, 16, 16, 4000, 2000, 0, 0, 0, 1);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 4000, 24, 16);
      run(0, 1000, -1, n);
      chk_int("longper.latency", n, 242);
      exp_all("longper", 8, 0, 0, 0, 24, 16, 4000, 4000, 0, 0, 0, 1);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 4000, 16, 16);
      cfrom[1] = 40;
      run(0, 1000, 250, n);
      chk_int("stall.latency", n, 288);
      exp_all("stall", 0, 0, 0, 0, 16, 0, 4000, 0, 0, 1, 0, 1);
      step();

      setup(2, 8, 16, 16, 4000, 4000, 4000, 4000, 16, 16);
      run(0, 1000, -1, n);
      chk_int("inclusive.latency", n, 162);
      exp_all("inclusive", 0, 0, 0, 0, 16, 16, 4000, 4000, 0, 0, 0, 1);
      step();

      setup(2, 8, 17, 17, 3999, 3999, 4000, 4000, 16, 16);
      run(0, 1000, -1, n);
      exp_all("outside", 8, 8, 8, 8, 16, 16, 4000, 4000, 0, 0, 0, 1);
      step();

      setup(2, 0, 12, 20, 2500, 14000, 4000, 4000, 16, 16);
      run(0, 1000, -1, n);
      chk_int("noper.latency", n, 34);
      exp_all("noper", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 2000, 16, 16);
      feed(0, 81);
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_all("abort", 0, 0, 0, 3, 16, 16, 4000, 2000, 0, 0, 0, 0);
      feed(81, 40);
      exp_all("abort_hold", 0, 0, 0, 3, 16, 16, 4000, 2000, 0, 0, 0, 0);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 2000, 16, 16);
      feed(0, 81);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1;
      feed(81, 40);
      exp_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      setup(2, 8, 12, 20, 2500, 14000, 4000, 2000, 16, 16);
      feed(0, 81);
      start = 1'b1;
      step();
      start = 1'b0;
      exp_all("start_in_run", 0, 0, 0, 3, 16, 16, 4000, 2000, 0, 0, 1, 0);
      run(81, 1000, -1, n);
      chk_int("rerun.latency", n, 81);
      exp_all("rerun", 0, 0, 0, 8, 16, 16, 4000, 2000, 0, 0, 0, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      exp_all("start_in_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      amp[1] = 4000;
      run(162, 1000, -1, n);
      chk_int("restart.latency", n, 160);
      exp_all("restart", 0, 0, 0, 0, 16, 16, 4000, 4000, 0, 0, 0, 1);

      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
